// File: rtl/seq_gen0100.sv
// rtl/seq_gen0100.sv - serial MSB-first word transmitter with repeat and idle gaps
module seq_gen0100 #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 4,
  parameter int GAP_LEN = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_repeat,
  input  logic              abort,
  output logic              seq_out,
  output logic              seq_valid,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_LEN > 0) ? GAP_W'(GAP_LEN - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] saved_word;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  rep_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  // Moore output decode: the line idles high so a downstream detector resets between words
  assign seq_out    = (state == S_SHIFT) ? shift_reg[DATA_W-1] : 1'b1;
  assign seq_valid  = (state == S_SHIFT);
  assign load_ready = (state == S_IDLE);
  assign busy       = (state == S_SHIFT) || (state == S_GAP);

  // Transmit sequencer: load, shift, reload per repetition, gap, finish with a done pulse
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      shift_reg  <= '0;
      saved_word <= '0;
      bit_cnt    <= '0;
      rep_cnt    <= '0;
      gap_cnt    <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // abort wins over a coincident load
          if (load_valid && !abort) begin
            shift_reg  <= load_data;
            saved_word <= load_data;
            rep_cnt    <= load_repeat;
            bit_cnt    <= BIT_LAST;
            state      <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (abort) begin
            state      <= S_IDLE;
            shift_reg  <= '0;
            saved_word <= '0;
            bit_cnt    <= '0;
            rep_cnt    <= '0;
            gap_cnt    <= '0;
          end else if (bit_cnt == '0) begin
            if (rep_cnt == '0) begin
              state     <= S_IDLE;
              shift_reg <= '0;
              done      <= 1'b1;
            end else begin
              // rep_cnt is only decremented when non-zero, so the maximum count never wraps
              rep_cnt   <= rep_cnt - 1'b1;
              shift_reg <= saved_word;
              bit_cnt   <= BIT_LAST;
              if (GAP_LEN > 0) begin
                gap_cnt <= GAP_LAST;
                state   <= S_GAP;
              end
            end
          end else begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
            bit_cnt   <= bit_cnt - 1'b1;
          end
        end

        S_GAP: begin
          if (abort) begin
            state      <= S_IDLE;
            shift_reg  <= '0;
            saved_word <= '0;
            bit_cnt    <= '0;
            rep_cnt    <= '0;
            gap_cnt    <= '0;
          end else if (gap_cnt == '0) begin
            state <= S_SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          shift_reg  <= '0;
          saved_word <= '0;
          bit_cnt    <= '0;
          rep_cnt    <= '0;
          gap_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen0100.sv
// tb/tb_seq_gen0100.sv - self-checking bench for seq_gen0100
module tb_seq_gen0100;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int GAP_LEN = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic [CNT_W-1:0]  load_repeat = '0;
  logic              abort = 1'b0;
  logic              load_ready, seq_out, seq_valid, busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int done_cnt = 0;
  int det_cnt = 0;
  logic [3:0] hist = 4'hF;
  logic cap[$];

  // model: one entry per cycle of line activity, {bit, valid}
  typedef struct packed { logic b; logic v; } ent_t;
  ent_t q[$];
  logic exp_done = 1'b0;
  logic model_live = 1'b0;
  int model_len = 0;

  seq_gen0100 #(.DATA_W(DATA_W), .CNT_W(CNT_W), .GAP_LEN(GAP_LEN)) dut (
    .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_repeat(load_repeat), .abort(abort),
    .seq_out(seq_out), .seq_valid(seq_valid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic build(input logic [DATA_W-1:0] d, input int rep);
    for (int r = 0; r <= rep; r++) begin
      for (int i = DATA_W - 1; i >= 0; i--) q.push_back('{b: d[i], v: 1'b1});
      if (r < rep) for (int g = 0; g < GAP_LEN; g++) q.push_back('{b: 1'b1, v: 1'b0});
    end
    model_len = q.size();
  endtask

  // behavioural model update on each edge
  always @(posedge clock) begin
    logic nd;
    nd = 1'b0;
    if (!reset) begin
      q.delete();
      model_live = 1'b1;
    end else if (q.size() != 0) begin
      if (abort) q.delete();
      else begin
        void'(q.pop_front());
        if (q.size() == 0) nd = 1'b1;
      end
    end else if (load_valid && !abort) begin
      build(load_data, int'(load_repeat));
    end
    exp_done = nd;
  end

  // compare, capture and reference 0100 detector, away from the active edge
  always @(negedge clock) begin
    if (model_live) begin
      check("seq_out",    {31'd0, seq_out},    {31'd0, (q.size() != 0) ? q[0].b : 1'b1});
      check("seq_valid",  {31'd0, seq_valid},  {31'd0, (q.size() != 0) ? q[0].v : 1'b0});
      check("busy",       {31'd0, busy},       {31'd0, q.size() != 0});
      check("load_ready", {31'd0, load_ready}, {31'd0, q.size() == 0});
      check("done",       {31'd0, done},       {31'd0, exp_done});
    end
    if (seq_valid === 1'b1) cap.push_back(seq_out);
    hist = {hist[2:0], seq_out};
    if (hist == 4'b0100) det_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load_word(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] r);
    load_data = d;
    load_repeat = r;
    load_valid = 1'b1;
    step(1);
    hs_cyc = cyc;
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int idx);
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        idx = cyc - hs_cyc + 1;
        break;
      end
    end
    if (idx < 0) begin
      checks++;
      failures++;
      $display("FAIL wait_done: no done within %0d cycles", limit);
    end
  endtask

  function automatic logic [31:0] cap_val(input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n && i < cap.size(); i++) v = {v[30:0], cap[i]};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, c1, c2, dc, d0, errs;

    // reset then idle
    step(2);
    check("rst_seq_out", {31'd0, seq_out}, 32'd1);
    check("rst_seq_valid", {31'd0, seq_valid}, 32'd0);
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    step(10);

    // single word 0100_0100
    cap.delete();
    d0 = det_cnt;
    load_word(8'b0100_0100, 4'd0);
    check("single_model_len", model_len, 32'd8);
    wait_done(40, idx);
    check("single_done_cycle", idx, 32'd9);
    check("single_ready_on_done", {31'd0, load_ready}, 32'd1);
    check("single_bits", cap_val(8), 32'h44);
    check("single_bit_count", cap.size(), 32'd8);
    check("detector_hits", det_cnt - d0, 32'd2);

    // repeat with gap
    step(3);
    cap.delete();
    load_word(8'hA5, 4'd1);
    check("rep_model_len", model_len, 32'd18);
    wait_done(60, idx);
    check("rep_done_cycle", idx, 32'd19);
    check("rep_bits", cap_val(16), 32'hA5A5);

    // back-to-back words with load_valid held
    step(3);
    cap.delete();
    load_data = 8'hF0;
    load_repeat = 4'd0;
    load_valid = 1'b1;
    step(1);
    hs_cyc = cyc;
    load_data = 8'h0F;
    wait_done(40, idx);
    c1 = cyc;
    check("b2b_first_done", idx, 32'd9);
    step(1);
    load_valid = 1'b0;
    hs_cyc = cyc;
    wait_done(40, idx);
    c2 = cyc;
    check("b2b_second_done", idx, 32'd9);
    check("b2b_done_spacing", c2 - c1, 32'd9);
    check("b2b_bits", cap_val(16), 32'hF00F);

    // busy load ignored, then abort during bit 4
    step(3);
    cap.delete();
    load_word(8'h3C, 4'd3);
    step(1);
    load_valid = 1'b1;
    load_data = 8'hFF;
    step(1);
    load_valid = 1'b0;
    step(1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_seq_out", {31'd0, seq_out}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    dc = done_cnt;
    step(20);
    check("abort_no_done", done_cnt - dc, 32'd0);
    check("abort_bits", cap_val(4), 32'h3);
    check("abort_bit_count", cap.size(), 32'd4);

    // abort coinciding with load in idle
    load_valid = 1'b1;
    abort = 1'b1;
    load_data = 8'hFF;
    step(1);
    load_valid = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    step(2);
    cap.delete();
    load_word(8'h81, 4'd0);
    wait_done(40, idx);
    check("after_abort_done", idx, 32'd9);
    check("after_abort_bits", cap_val(8), 32'h81);

    // maximum repeat count
    step(3);
    cap.delete();
    load_word(8'h55, 4'hF);
    check("max_model_len", model_len, 32'd158);
    wait_done(400, idx);
    check("max_done_cycle", idx, 32'd159);
    check("max_bit_count", cap.size(), 32'd128);
    errs = 0;
    for (int i = 0; i < cap.size(); i++) if (cap[i] !== ((i % 2) == 1)) errs++;
    check("max_bits", errs, 32'd0);

    // reset in the middle of a run
    step(2);
    load_word(8'h55, 4'hF);
    step(19);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("midrst_seq_out", {31'd0, seq_out}, 32'd1);
    check("midrst_seq_valid", {31'd0, seq_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_load_ready", {31'd0, load_ready}, 32'd1);
    dc = done_cnt;
    step(200);
    check("midrst_no_done", done_cnt - dc, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_gen0100.md
Name: seq_gen0100

Overview:
- Serial bit-stream transmitter: the stimulus end of the "0100" Moore sequence-detector interface.
- Accepts a parallel word through a valid/ready handshake and emits it MSB-first, one bit per clock, on `seq_out`.
- Can repeat the word a programmable number of times, with idle '1' gap bits between repetitions.
- Line idles at '1', so a downstream detector returns to its reset state between words.

Parameters:
- DATA_W, 8, width of the transmitted word; must be >= 2.
- CNT_W, 4, width of the repeat-count field.
- GAP_LEN, 2, number of idle '1' bits inserted between repetitions of the same word; 0 is legal and means no gap.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising clock edge initialises the block.
- load_valid  input  1  word/repeat pair on load_data/load_repeat is valid.
- load_ready  output  1  block can accept a word; high only in IDLE.
- load_data  input  DATA_W  word to transmit; bit DATA_W-1 goes first.
- load_repeat  input  CNT_W  additional repetitions; word is sent load_repeat+1 times.
- abort  input  1  synchronous abort of the current transmission.
- seq_out  output  1  serial data; '1' whenever not in SHIFT.
- seq_valid  output  1  high exactly when seq_out carries a data bit.
- busy  output  1  high in SHIFT or GAP.
- done  output  1  registered one-cycle pulse after the last bit of the last repetition.

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE; shift_reg, saved word, bit_cnt, rep_cnt, gap_cnt = 0; done=0.
  - Resulting outputs: seq_out=1, seq_valid=0, busy=0, load_ready=1.
  - Reset mid-transmission discards the word with no done pulse. Reset has priority over abort and load.
- Moore outputs, decoded from state and shift_reg only:
  - SHIFT: seq_out=shift_reg[DATA_W-1], seq_valid=1.
  - Otherwise: seq_out=1, seq_valid=0.
  - load_ready = (state==IDLE). busy = (state==SHIFT || state==GAP).
- IDLE:
  - On an edge with load_valid && load_ready && !abort: shift_reg and saved word <= load_data; rep_cnt <= load_repeat; bit_cnt <= DATA_W-1; go to SHIFT.
  - First data bit is visible the cycle after the handshake edge (latency 1).
- SHIFT, each edge: shift_reg shifts left by 1 (zero fill) and bit_cnt decrements.
- SHIFT when bit_cnt==0 (last bit of a repetition on the line):
  - rep_cnt==0: go to IDLE and set done=1 for exactly the next cycle.
  - rep_cnt!=0 and GAP_LEN>0: rep_cnt--, shift_reg <= saved word, bit_cnt <= DATA_W-1, gap_cnt <= GAP_LEN-1, go to GAP.
  - rep_cnt!=0 and GAP_LEN==0: same reload, stay in SHIFT; bits run back-to-back.
- GAP: gap_cnt decrements each edge; when gap_cnt==0, go to SHIFT.
- done: cleared on every edge where it is not being set.
- Total cycles from first bit to done: (load_repeat+1)*DATA_W + load_repeat*GAP_LEN.
- Back-to-back words: load_valid held high is accepted on the done cycle (IDLE), so consecutive words are separated by exactly one idle '1' bit.
- load_valid while busy: ignored; load_ready=0 and nothing is captured.
- abort==1 at an edge in SHIFT or GAP: go to IDLE next cycle; counters cleared; no done pulse.
- abort in IDLE: no effect. abort coinciding with load_valid in IDLE: abort wins and the word is not captured.
- load_repeat at its maximum value (2^CNT_W-1) must send exactly 2^CNT_W copies; rep_cnt must not wrap.
- Unreachable state encodings return to IDLE on the next edge.

Test Plan:
- Reset, then idle: drive reset=0 for 2 edges, then release → seq_out=1, seq_valid=0, load_ready=1, busy=0, done=0 for 10 further cycles with no load_valid.
- Single word (DATA_W=8, GAP_LEN=2): load_data=8'b0100_0100, load_repeat=0 → seq_out=0,1,0,0,0,1,0,0 on cycles 1-8 with seq_valid=1; done=1 on cycle 9 only; load_ready=1 on cycle 9. A reference 0100 detector fed the stream fires twice.
- Repeat with gap: load_data=8'hA5, load_repeat=1 → bits 1,0,1,0,0,1,0,1, then 2 cycles seq_out=1 with seq_valid=0, then the same 8 bits; done on cycle 19.
- Back-to-back: load_valid held high with 8'hF0 then 8'h0F, load_repeat=0 → exactly one idle '1' cycle (the done cycle) between the two words; second done 9 cycles after the first.
- Abort and busy-load: load 8'h3C, repeat 3; assert load_valid with 8'hFF during bit 2 → ignored. Assert abort during bit 4 → IDLE next cycle, seq_out=1, no done pulse. A following load of 8'h81 transmits correctly.
- Reset mid-operation and max repeat: load_repeat=4'hF with 8'h55 → 16 copies, done at cycle 16*8+15*2+1=159. A second run with reset=0 at bit 20 → outputs return to reset values next cycle, no done pulse.
